vga_number_sync: RTL

- Controller between the game logic and the screen renderer; owns the 48-bit numbers_concat bus that the renderer draws.
- Accepts number/blink updates through a valid/ready handshake and holds each one in a shadow register.
- Commits the update only at the start of vertical blanking, so a frame never shows a partial update.
- Generates a frame-locked blink phase that replaces selected digit slots with a blank code.

---
 rtl/vga_number_sync_pkg.sv | 10 +
 rtl/vga_number_sync_if.sv | 9 +
 rtl/vga_blink_gen.sv | 23 ++
 rtl/vga_number_sync.sv | 64 ++++++
 4 files changed

// File: rtl/vga_number_sync_pkg.sv
// vga_number_sync_pkg: shared slot layout, codes and controller state encoding
package vga_number_sync_pkg;
  localparam int SLOTS = 12;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int V_ACTIVE = 480;
  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, COMMIT = 2'd2} state_t;
  function automatic int slot_lo(input int n, input int i);
    return 4 * (n - 1 - i);
  endfunction
endpackage

// File: rtl/vga_number_sync_if.sv
// vga_number_sync_if: valid/ready update channel from game logic to the controller
interface vga_number_sync_if import vga_number_sync_pkg::*; #(parameter int N = SLOTS);
  logic           upd_valid;
  logic           upd_ready;
  logic [4*N-1:0] upd_data;
  logic [N-1:0]   upd_blink;
  modport master(output upd_valid, upd_data, upd_blink, input upd_ready);
  modport slave(input upd_valid, upd_data, upd_blink, output upd_ready);
endinterface

// File: rtl/vga_blink_gen.sv
// vga_blink_gen: frame counter producing the blink phase, restarted on clear
module vga_blink_gen #(
  parameter int BLINK_FRAMES = 30,
  parameter int CNT_W = 5
) (
  input  logic clk_pix,
  input  logic rst,
  input  logic tick,
  input  logic clear,
  output logic phase
);
  logic [CNT_W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CNT_W'(BLINK_FRAMES - 1);
  always_ff @(posedge clk_pix)
    if (!rst || clear) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (tick) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) phase <= ~phase;
    end
endmodule

// File: rtl/vga_number_sync.sv
// vga_number_sync: shadows digit/blink updates and commits them at vblank start
module vga_number_sync import vga_number_sync_pkg::*; #(
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int BLINK_FRAMES = 30,
  parameter int CNT_W = 5
) (
  input  logic                  clk_pix,
  input  logic                  rst,
  input  logic [9:0]            sy,
  vga_number_sync_if.slave      upd,
  output logic [4*SLOTS-1:0]    numbers_concat,
  output logic                  commit_pulse,
  output logic                  frame_tick
);
  state_t state, nxt;
  logic [9:0] sy_q;
  logic vblank_start, phase;
  logic [4*SLOTS-1:0] shadow_d, digits, shown;
  logic [SLOTS-1:0] shadow_b, blink;
  assign vblank_start = sy == 10'(V_ACTIVE_P) && sy_q != 10'(V_ACTIVE_P);
  always_comb
    nxt = state == IDLE    ? (upd.upd_valid && upd.upd_ready ? PENDING : IDLE) :
          state == PENDING ? (vblank_start ? COMMIT : PENDING) : IDLE;
  always_comb begin
    shown = digits;
    for (int i = 0; i < SLOTS; i++)
      if (blink[i] && !phase) shown[slot_lo(SLOTS, i) +: 4] = BLANK_CODE;
  end
  always_ff @(posedge clk_pix)
    if (!rst) begin
      state          <= IDLE;
      sy_q           <= '0;
      shadow_d       <= {SLOTS{BLANK_CODE}};
      digits         <= {SLOTS{BLANK_CODE}};
      shadow_b       <= '0;
      blink          <= '0;
      upd.upd_ready  <= 1'b0;
      commit_pulse   <= 1'b0;
      frame_tick     <= 1'b0;
      numbers_concat <= {SLOTS{BLANK_CODE}};
    end else begin
      state          <= nxt;
      sy_q           <= sy;
      frame_tick     <= vblank_start;
      upd.upd_ready  <= nxt == IDLE;
      commit_pulse   <= nxt == COMMIT;
      numbers_concat <= shown;
      if (state == IDLE && nxt == PENDING) begin
        shadow_d <= upd.upd_data;
        shadow_b <= upd.upd_blink;
      end
      if (state == COMMIT) begin
        digits <= shadow_d;
        blink  <= shadow_b;
      end
    end
  vga_blink_gen #(.BLINK_FRAMES(BLINK_FRAMES), .CNT_W(CNT_W)) u_blink (
    .clk_pix(clk_pix),
    .rst(rst),
    .tick(vblank_start && state != COMMIT),
    .clear(state == COMMIT),
    .phase(phase)
  );
endmodule
